i2c_bit_generator: RTL and testbench

I2C_BIT_GENERATOR -- requirements
Module: i2c_bit_generator

---
 rtl/i2c_bit_generator.sv | 189 ++++++++++++++++++
 tb/tb_i2c_bit_generator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bit_generator.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_bit_generator
//  Purpose  : I2C bit-level engine. Turns one START / STOP / WRITE / READ
//             command into four timed phases of open-drain SCL/SDA levels.
//             Each phase lasts prescale+1 clk cycles. SCL low-stretching by
//             a slave holds phase 1.
//  Ports    : clk                 - rising-edge clock
//             rst_                - asynchronous active-low reset
//             prescale[PRESC_W]   - phase length minus one (latched at accept)
//             cmd[3], cmd_valid   - command request (1 START,2 STOP,3 WRITE,4 READ)
//             cmd_ready           - high while idle
//             din                 - WRITE data bit (latched at accept)
//             dout                - bit sampled by the last READ
//             done                - one-cycle completion pulse
//             busy                - command in progress
//             scl_in, sda_in      - raw bus levels (asynchronous)
//             scl_oe, sda_oe      - open-drain pull-low enables (registered)
//  Revision : 1.0  initial release
// ============================================================================
module i2c_bit_generator #(
   parameter int PRESC_W = 16
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic [PRESC_W-1:0] prescale,
   input  logic [2:0]         cmd,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               din,
   output logic               dout,
   output logic               done,
   output logic               busy,
   input  logic               scl_in,
   input  logic               sda_in,
   output logic               scl_oe,
   output logic               sda_oe
);

   // State codes equal the command codes so an accepted cmd maps directly.
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_STOP  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_READ  = 3'd4;

   logic [2:0]         r_state;
   logic [1:0]         r_phase;
   logic [PRESC_W-1:0] r_cnt;
   logic [PRESC_W-1:0] r_presc;
   logic               r_din;
   logic               r_dout;
   logic               r_done;
   logic               r_scl_oe;
   logic               r_sda_oe;
   logic               r_scl_s1, r_scl_s2;
   logic               r_sda_s1, r_sda_s2;

   logic [2:0]         w_state_nxt;
   logic [1:0]         w_phase_nxt;
   logic [PRESC_W-1:0] w_cnt_nxt;
   logic               w_done_nxt;
   logic               w_din_nxt;
   logic               w_scl_oe_nxt;
   logic               w_sda_oe_nxt;
   logic               w_accept;
   logic               w_cmd_ok;
   logic               w_hold;
   logic               w_sample;

   assign w_cmd_ok  = (cmd >= 3'd1) && (cmd <= 3'd4);
   assign w_accept  = cmd_valid && (r_state == S_IDLE) && w_cmd_ok;
   // Slave stretching: phase 1 stays at its reload value while SCL reads low.
   assign w_hold    = (r_phase == 2'd1) && (r_cnt == r_presc) && !r_scl_s2;
   assign w_sample  = (r_state == S_READ) && (r_phase == 2'd2) && (r_cnt == '0);
   assign w_din_nxt = w_accept ? din : r_din;

   // Phase sequencing
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      if (r_state == S_IDLE) begin
         if (w_accept) begin
            w_state_nxt = cmd;
            w_phase_nxt = 2'd0;
            w_cnt_nxt   = prescale;
         end
      end else if (w_hold) begin
         w_cnt_nxt = r_cnt;
      end else if (r_cnt == '0) begin
         if (r_phase == 2'd3) begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = 2'd0;
            w_done_nxt  = 1'b1;
         end else begin
            w_phase_nxt = r_phase + 2'd1;
            w_cnt_nxt   = r_presc;
         end
      end else begin
         w_cnt_nxt = r_cnt - PRESC_W'(1);
      end
   end

   // Line levels are computed from the state/phase about to be entered, so
   // they appear registered in the first cycle of that phase. Fields a phase
   // does not mention keep their previous value; IDLE holds both lines.
   always_comb begin
      w_scl_oe_nxt = r_scl_oe;
      w_sda_oe_nxt = r_sda_oe;
      case (w_state_nxt)
         S_START: begin
            case (w_phase_nxt)
               2'd0:    w_sda_oe_nxt = 1'b0;
               2'd1:    w_scl_oe_nxt = 1'b0;
               2'd2:    w_sda_oe_nxt = 1'b1;
               default: w_scl_oe_nxt = 1'b1;
            endcase
         end
         S_STOP: begin
            case (w_phase_nxt)
               2'd0: begin
                  w_scl_oe_nxt = 1'b1;
                  w_sda_oe_nxt = 1'b1;
               end
               2'd1:    w_scl_oe_nxt = 1'b0;
               2'd2:    ;
               default: w_sda_oe_nxt = 1'b0;
            endcase
         end
         S_WRITE, S_READ: begin
            w_sda_oe_nxt = (w_state_nxt == S_WRITE) ? ~w_din_nxt : 1'b0;
            case (w_phase_nxt)
               2'd0:    w_scl_oe_nxt = 1'b1;
               2'd1:    w_scl_oe_nxt = 1'b0;
               2'd2:    ;
               default: w_scl_oe_nxt = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state  <= S_IDLE;
         r_phase  <= 2'd0;
         r_cnt    <= '0;
         r_presc  <= '0;
         r_din    <= 1'b0;
         r_dout   <= 1'b0;
         r_done   <= 1'b0;
         r_scl_oe <= 1'b0;
         r_sda_oe <= 1'b0;
         r_scl_s1 <= 1'b1;
         r_scl_s2 <= 1'b1;
         r_sda_s1 <= 1'b1;
         r_sda_s2 <= 1'b1;
      end else begin
         r_scl_s1 <= scl_in;
         r_scl_s2 <= r_scl_s1;
         r_sda_s1 <= sda_in;
         r_sda_s2 <= r_sda_s1;
         r_state  <= w_state_nxt;
         r_phase  <= w_phase_nxt;
         r_cnt    <= w_cnt_nxt;
         r_done   <= w_done_nxt;
         r_din    <= w_din_nxt;
         r_scl_oe <= w_scl_oe_nxt;
         r_sda_oe <= w_sda_oe_nxt;
         if (w_accept) begin
            r_presc <= prescale;
         end
         if (w_sample) begin
            r_dout <= r_sda_s2;
         end
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign dout      = r_dout;
   assign scl_oe    = r_scl_oe;
   assign sda_oe    = r_sda_oe;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bit_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_bit_generator
//  Purpose  : Directed self-checking bench for i2c_bit_generator. Expected
//             completion cycles (and READ data) are queued when a command is
//             issued and compared when done pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_bit_generator;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic [15:0] prescale = '0;
   logic [2:0]  cmd = '0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        din = 1'b0;
   logic        dout;
   logic        done;
   logic        busy;
   logic        scl_in = 1'b1;
   logic        sda_in = 1'b1;
   logic        scl_oe;
   logic        sda_oe;

   i2c_bit_generator #(.PRESC_W(16)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .prescale  (prescale),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .din       (din),
      .dout      (dout),
      .done      (done),
      .busy      (busy),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .scl_oe    (scl_oe),
      .sda_oe    (sda_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   cyc;
      bit   chk_dout;
      logic exp_dout;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   acc_cyc = -100000;
   logic tr_scl [0:255];
   logic tr_sda [0:255];
   logic tr_busy[0:255];
   logic tr_rdy [0:255];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cycle counter plus per-cycle trace relative to the last accept cycle.
   always @(posedge clk) begin
      int idx;
      cyc++;
      #2;
      idx = cyc - acc_cyc;
      if (idx >= 0 && idx < 256) begin
         tr_scl[idx]  = scl_oe;
         tr_sda[idx]  = sda_oe;
         tr_busy[idx] = busy;
         tr_rdy[idx]  = cmd_ready;
      end
   end

   // Scoreboard: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_ === 1'b1 && done === 1'b1) begin
         check("done_expected", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("done_cycle", cyc, e.cyc);
            if (e.chk_dout) check("read_dout", {31'd0, dout}, {31'd0, e.exp_dout});
         end
      end
   end

   // Drives a request in the current cycle; accept happens at the next edge.
   task automatic issue(input logic [2:0] c, input logic d, input logic [15:0] p);
      cmd       = c;
      din       = d;
      prescale  = p;
      cmd_valid = 1'b1;
      acc_cyc   = cyc;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Expected completion: four phases of p+1 cycles after accept, done next.
   task automatic expect_done(input int p, input int extra, input bit chk, input logic d);
      exp_t e;
      e.cyc      = acc_cyc + 4 * (p + 1) + 1 + extra;
      e.chk_dout = chk;
      e.exp_dout = d;
      sb.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < limit);
      if (done !== 1'b1) check({tag, "_timeout"}, {31'd0, done}, 32'd1);
   endtask

   initial begin
      int a;
      int bad;

      // ---- reset values ----
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_done",      {31'd0, done},      32'd0);
      check("rst_scl_oe",    {31'd0, scl_oe},    32'd0);
      check("rst_sda_oe",    {31'd0, sda_oe},    32'd0);
      check("rst_dout",      {31'd0, dout},      32'd0);
      rst_ = 1'b1;
      @(posedge clk);
      #1;

      // ---- START, prescale 3: sda_oe at +9, scl_oe at +13, done at +17 ----
      issue(3'd1, 1'b0, 16'd3);
      expect_done(3, 0, 1'b0, 1'b0);
      wait_done("start", 40);
      check("start_sda_c8",   {31'd0, tr_sda[8]},   32'd0);
      check("start_sda_c9",   {31'd0, tr_sda[9]},   32'd1);
      check("start_scl_c12",  {31'd0, tr_scl[12]},  32'd0);
      check("start_scl_c13",  {31'd0, tr_scl[13]},  32'd1);
      check("start_busy_c1",  {31'd0, tr_busy[1]},  32'd1);
      check("start_busy_c16", {31'd0, tr_busy[16]}, 32'd1);
      check("start_busy_c17", {31'd0, tr_busy[17]}, 32'd0);
      check("start_rdy_c17",  {31'd0, tr_rdy[17]},  32'd1);

      // ---- back-to-back WRITEs, prescale 0; din/prescale changes ignored ----
      issue(3'd3, 1'b0, 16'd0);
      din      = 1'b1;
      prescale = 16'd5;
      expect_done(0, 0, 1'b0, 1'b0);
      wait_done("write0", 20);
      bad = 0;
      for (int k = 1; k <= 4; k++) if (tr_sda[k] !== 1'b1) bad++;
      check("write0_sda_low", bad, 0);
      check("write0_scl_ph0", {31'd0, tr_scl[1]}, 32'd1);
      check("write0_scl_ph1", {31'd0, tr_scl[2]}, 32'd0);
      check("write0_scl_ph2", {31'd0, tr_scl[3]}, 32'd0);
      check("write0_scl_ph3", {31'd0, tr_scl[4]}, 32'd1);
      issue(3'd3, 1'b1, 16'd0);
      expect_done(0, 0, 1'b0, 1'b0);
      wait_done("write1", 20);
      bad = 0;
      for (int k = 1; k <= 4; k++) if (tr_sda[k] !== 1'b0) bad++;
      check("write1_sda_rel", bad, 0);
      check("write1_scl_ph1", {31'd0, tr_scl[2]}, 32'd0);

      // ---- READ: sda falls after the sample point -> 1 ----
      issue(3'd4, 1'b0, 16'd1);
      a = acc_cyc;
      expect_done(1, 0, 1'b1, 1'b1);
      wait_until(a + 5);
      sda_in = 1'b0;
      wait_done("read1", 30);
      check("read1_dout", {31'd0, dout}, 32'd1);
      bad = 0;
      for (int k = 1; k <= 8; k++) if (tr_sda[k] !== 1'b0) bad++;
      check("read1_sda_rel", bad, 0);
      check("read1_scl_ph2", {31'd0, tr_scl[5]}, 32'd0);
      check("read1_scl_ph3", {31'd0, tr_scl[7]}, 32'd1);

      // ---- READ: sda falls early enough to be sampled -> 0 ----
      sda_in = 1'b1;
      issue(3'd4, 1'b0, 16'd1);
      a = acc_cyc;
      expect_done(1, 0, 1'b1, 1'b0);
      wait_until(a + 3);
      sda_in = 1'b0;
      wait_done("read0", 30);
      check("read0_dout", {31'd0, dout}, 32'd0);
      sda_in = 1'b1;

      // ---- stretching: slave holds SCL low 20 cycles into ph1 ----
      // Ph1 starts at +3; release at +23 reaches the synchronizer output at
      // +25, after which ph1 needs two more cycles: done at +31 (not +9).
      scl_in = 1'b0;
      issue(3'd3, 1'b1, 16'd1);
      a = acc_cyc;
      expect_done(1, 22, 1'b0, 1'b0);
      wait_until(a + 23);
      scl_in = 1'b1;
      wait_done("stretch", 80);
      bad = 0;
      for (int k = 3; k <= 26; k++) if (tr_scl[k] !== 1'b0) bad++;
      check("stretch_scl_ph1", bad, 0);
      check("stretch_scl_ph3", {31'd0, tr_scl[29]}, 32'd1);

      // ---- invalid command: ignored ----
      @(posedge clk);
      #1;
      cmd       = 3'd6;
      cmd_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("invalid_busy",  {31'd0, busy},      32'd0);
         check("invalid_ready", {31'd0, cmd_ready}, 32'd1);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;

      // ---- reset during STOP ph2: lines released at once, no done ----
      issue(3'd2, 1'b0, 16'd3);
      a = acc_cyc;
      wait_until(a + 10);
      check("stop_scl_ph0",    {31'd0, tr_scl[1]}, 32'd1);
      check("stop_sda_ph2",    {31'd0, sda_oe},    32'd1);
      check("stop_scl_ph2",    {31'd0, scl_oe},    32'd0);
      rst_ = 1'b0;
      #1;
      check("rstmid_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("rstmid_scl_oe", {31'd0, scl_oe}, 32'd0);
      check("rstmid_busy",   {31'd0, busy},   32'd0);
      @(posedge clk);
      #1;
      rst_ = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("post_rst_sda",   {31'd0, sda_oe},    32'd0);
      check("sb_drained",     sb.size(),          0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
